// File: rtl/temp_meas_sequencer.sv
// temp_meas_sequencer: sequences the pulse-duration temperature measurement.
// It enables the sensor oscillator, waits a settling time, then measures
// 2^NAVG_LOG2 low phases of the synchronized sensor pulse. The averaged
// duration goes out over a valid/ready handshake. A per-sample watchdog
// aborts a stalled run.
// Optional feature macro: TEMP_SEQ_CONT_EN adds the `cont` input for
// back-to-back runs without re-settling.
//
// Handshake: result_valid rises when a result is available and holds it,
// together with a stable result_data, until result_valid & result_ready
// are both 1 on a rising clock edge. The transfer happens on that edge.
module temp_meas_sequencer #(
  parameter int CNT_W     = 12,
  parameter int NAVG_LOG2 = 2,
  parameter int SETTLE    = 16,
  parameter int TIMEOUT   = 8191
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signal_in,
`ifdef TEMP_SEQ_CONT_EN
  input  logic             cont,
`endif
  output logic             sensor_en,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_data,
  output logic             timeout_err
);

  localparam int ACC_W = CNT_W + NAVG_LOG2;
  localparam int IDX_W = NAVG_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << NAVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_HIGH, S_WAIT_LOW, S_COUNT, S_RESULT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic [SET_W-1:0]   set_q, set_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   res_q, res_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic               abort;
  logic               sig_s;
  logic               cont_w;
  logic [WD_W-1:0]    wd_inc;
  logic               wd_expire;
  logic [ACC_W-1:0]   acc_sum;

`ifdef TEMP_SEQ_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif

  assign sig_s     = sync_q[1];
  assign wd_inc    = wd_q + 1'b1;
  assign wd_expire = (wd_inc == WD_W'(TIMEOUT));
  assign acc_sum   = acc_q + ACC_W'(cnt_q);

  // Two-flop synchronizer for the asynchronous sensor pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], signal_in};
  end

  // State, counters, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; a completing sample takes priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          set_d   = '0;
        end
      end
      S_SETTLE: begin
        set_d = set_q + 1'b1;
        if (set_q == SET_W'(SETTLE - 1)) begin
          state_d = S_WAIT_HIGH;
          acc_d   = '0;
          idx_d   = '0;
          wd_d    = '0;
        end
      end
      S_WAIT_HIGH: begin
        wd_d = wd_inc;
        if (sig_s) state_d = S_WAIT_LOW;
        if (wd_expire) abort = 1'b1;
      end
      S_WAIT_LOW: begin
        wd_d = wd_inc;
        if (!sig_s) begin
          state_d = S_COUNT;
          cnt_d   = CNT_W'(1);
        end
        if (wd_expire) abort = 1'b1;
      end
      S_COUNT: begin
        if (sig_s) begin
          acc_d = acc_sum;
          idx_d = idx_q + 1'b1;
          wd_d  = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_RESULT;
            res_d   = CNT_W'(acc_sum >> NAVG_LOG2);
          end else begin
            state_d = S_WAIT_LOW;
          end
        end else begin
          wd_d = wd_inc;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (wd_expire) abort = 1'b1;
        end
      end
      S_RESULT: begin
        if (result_ready) begin
          if (cont_w) begin
            state_d = S_WAIT_HIGH;
            acc_d   = '0;
            idx_d   = '0;
            wd_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      acc_d   = '0;
      idx_d   = '0;
    end
  end

  assign tmo_d  = abort;
  assign busy_d = (state_d != S_IDLE);

  assign sensor_en    = (state_q inside {S_SETTLE, S_WAIT_HIGH, S_WAIT_LOW, S_COUNT}) ||
                        ((state_q == S_RESULT) && cont_w);
  assign result_valid = (state_q == S_RESULT);
  assign result_data  = res_q;
  assign busy         = busy_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_temp_meas_sequencer.sv
// Testbench for temp_meas_sequencer: table-driven runs, hand-written corner
// sequences and randomized runs checked against an arithmetic average model.
module tb_temp_meas_sequencer;

  localparam int CNT_W     = 12;
  localparam int NAVG_LOG2 = 2;
  localparam int SETTLE    = 16;
  localparam int TIMEOUT   = 8191;
  localparam int SAT       = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic signal_in = 1'b1;
  logic result_ready = 1'b1;
  logic sensor_en, busy, result_valid, timeout_err;
  logic [CNT_W-1:0] result_data;
`ifdef TEMP_SEQ_CONT_EN
  logic cont = 1'b0;
  logic watch = 1'b0;
  int   sen_low = 0;
`endif

  always #5 clk = ~clk;

  temp_meas_sequencer #(
    .CNT_W(CNT_W), .NAVG_LOG2(NAVG_LOG2), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .signal_in(signal_in),
`ifdef TEMP_SEQ_CONT_EN
    .cont(cont),
`endif
    .sensor_en(sensor_en),
    .busy(busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data(result_data),
    .timeout_err(timeout_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] obs_data[256];
  int obs_n = 0;
  int consumed = 0;

  // Record every completed handshake (valid & ready seen before the edge).
  always @(negedge clk) begin
    if (result_valid && result_ready && obs_n < 256) begin
      obs_data[obs_n] = result_data;
      obs_n = obs_n + 1;
    end
  end

`ifdef TEMP_SEQ_CONT_EN
  always @(negedge clk) begin
    if (watch && !sensor_en) sen_low = sen_low + 1;
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  // Reference: saturate each low phase, sum, divide by sample count.
  function automatic int model_avg(input int a, input int b, input int c, input int d);
    int s;
    s = (a > SAT ? SAT : a) + (b > SAT ? SAT : b) + (c > SAT ? SAT : c) + (d > SAT ? SAT : d);
    return s >> NAVG_LOG2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive_phase(input int l, input int h);
    signal_in = 1'b0;
    repeat (l) step();
    signal_in = 1'b1;
    repeat (h) step();
  endtask

  task automatic drain(input string name, input bit need_idle);
    bit done;
    logic [CNT_W-1:0] expv;
    done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      if (obs_n > consumed && (!need_idle || !busy)) done = 1'b1;
      else step();
    end
    if (obs_n > consumed && exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      check(name, 32'(obs_data[consumed]), 32'(expv));
      consumed++;
    end else begin
      check({name, "_arrived"}, 32'(obs_n > consumed), 32'd1);
    end
    if (need_idle) check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_one(input string name, input int l0, input int l1, input int l2,
                         input int l3, input int h, input int expv);
    exp_q.push_back(CNT_W'(expv));
    signal_in = 1'b1;
    pulse_start();
    repeat (SETTLE + 4) step();
    drive_phase(l0, h);
    drive_phase(l1, h);
    drive_phase(l2, h);
    drive_phase(l3, h);
    drain(name, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int l0, l1, l2, l3;
    int h;
    int expv;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int first, pulses, sen_cnt, valid_seen, sens_at, busy_at, obs_before, bad;
    int a, b, c, d;

    vecs[0] = '{l0: 100,  l1: 100, l2: 100, l3: 100, h: 50, expv: 100};
    vecs[1] = '{l0: 100,  l1: 101, l2: 102, l3: 103, h: 50, expv: 101};
    vecs[2] = '{l0: 1,    l1: 1,   l2: 1,   l3: 1,   h: 1,  expv: 1};
    vecs[3] = '{l0: 1,    l1: 2,   l2: 3,   l3: 4,   h: 2,  expv: 2};
    vecs[4] = '{l0: 4100, l1: 1,   l2: 1,   l3: 1,   h: 5,  expv: 1024};
    vecs[5] = '{l0: 7,    l1: 7,   l2: 7,   l3: 6,   h: 3,  expv: 6};

    // Reset values.
    #1;
    check("rst_sensor_en", 32'(sensor_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_data", 32'(result_data), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // sensor_en rises the cycle after start is sampled.
    exp_q.push_back(CNT_W'(100));
    start = 1'b1;
    @(negedge clk);
    check("sen_before_start", 32'(sensor_en), 0);
    step();
    start = 1'b0;
    @(negedge clk);
    check("sen_after_start", 32'(sensor_en), 1);
    check("busy_after_start", 32'(busy), 1);
    step();
    repeat (SETTLE + 2) step();
    for (int i = 0; i < 4; i++) drive_phase(100, 50);
    drain("first_run", 1'b1);

    // Table-driven runs.
    for (int i = 0; i < 6; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3,
              vecs[i].h, vecs[i].expv);
    end

    // Sensor stuck high: watchdog abort TIMEOUT cycles after arming.
    obs_before = obs_n;
    first = -1; pulses = 0; sen_cnt = 0; valid_seen = 0; sens_at = -1; busy_at = -1;
    signal_in = 1'b1;
    pulse_start();
    for (int k = 0; k < SETTLE + TIMEOUT + 20; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        pulses++;
        if (first < 0) begin
          first = k;
          sens_at = int'(sensor_en);
          busy_at = int'(busy);
        end
      end
      if (sensor_en) sen_cnt++;
      if (result_valid) valid_seen++;
    end
    step();
    check("tmo_pulses", 32'(pulses), 1);
    check("tmo_cycle", 32'(first), 32'(SETTLE + TIMEOUT));
    check("tmo_sen_cycles", 32'(sen_cnt), 32'(SETTLE + TIMEOUT));
    check("tmo_sen_at_pulse", 32'(sens_at), 0);
    check("tmo_busy_at_pulse", 32'(busy_at), 0);
    check("tmo_no_valid", 32'(valid_seen), 0);
    check("tmo_no_result", 32'(obs_n), 32'(obs_before));

    // Ready held low: data/valid stable, start ignored mid-run and in RESULT.
    result_ready = 1'b0;
    exp_q.push_back(CNT_W'(100));
    signal_in = 1'b1;
    pulse_start();
    repeat (SETTLE + 4) step();
    drive_phase(100, 50);
    drive_phase(100, 50);
    pulse_start();
    drive_phase(100, 50);
    drive_phase(100, 50);
    bad = 1;
    for (int i = 0; i < 50 && bad != 0; i++) begin
      @(negedge clk);
      if (result_valid) bad = 0;
    end
    check("stall_valid_rose", 32'(bad), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!result_valid || result_data !== CNT_W'(100)) bad++;
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
    end
    check("stall_stable_cycles_bad", 32'(bad), 0);
    step();
    result_ready = 1'b1;
    @(negedge clk);
    check("stall_valid_at_ready", 32'(result_valid), 1);
    @(negedge clk);
    check("stall_valid_dropped", 32'(result_valid), 0);
    drain("stall_result", 1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy) bad++;
    end
    check("stall_start_ignored", 32'(bad), 0);
    step();

    // Asynchronous reset in the middle of COUNT.
    signal_in = 1'b1;
    pulse_start();
    repeat (SETTLE + 4) step();
    signal_in = 1'b0;
    repeat (30) step();
    check("pre_reset_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sensor_en", 32'(sensor_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(result_valid), 0);
    check("arst_data", 32'(result_data), 0);
    check("arst_timeout", 32'(timeout_err), 0);
    signal_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || sensor_en) bad++;
    end
    check("post_reset_idle_bad", 32'(bad), 0);
    step();
    run_one("post_reset_run", 100, 101, 102, 103, 50, 101);

    // Randomized runs against the arithmetic model.
    for (int r = 0; r < 12; r++) begin
      a = $urandom_range(1, 400);
      b = $urandom_range(1, 400);
      c = $urandom_range(1, 400);
      d = $urandom_range(1, 400);
      run_one($sformatf("rand%0d", r), a, b, c, d, $urandom_range(1, 60), model_avg(a, b, c, d));
    end

`ifdef TEMP_SEQ_CONT_EN
    // Continuous mode: no re-settle, sensor_en never drops, then stop.
    cont = 1'b1;
    signal_in = 1'b1;
    pulse_start();
    repeat (SETTLE + 4) step();
    watch = 1'b1;
    for (int r = 0; r < 3; r++) begin
      a = $urandom_range(50, 200);
      b = $urandom_range(50, 200);
      c = $urandom_range(50, 200);
      d = $urandom_range(50, 200);
      if (r == 2) begin
        watch = 1'b0;
        cont = 1'b0;
      end
      exp_q.push_back(CNT_W'(model_avg(a, b, c, d)));
      drive_phase(a, 5);
      drive_phase(b, 5);
      drive_phase(c, 5);
      drive_phase(d, 5);
      drain($sformatf("cont%0d", r), r == 2);
    end
    check("cont_sensor_low_cycles", 32'(sen_low), 0);
    check("cont_stop_sensor_en", 32'(sensor_en), 0);
`endif

    repeat (5) step();
    check("result_count", 32'(obs_n), 32'(consumed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
